// File: rtl/rgbw_pkg.sv
// Shared types and default timing for the RGBW single-wire LED stream blocks.
// Timing defaults assume a 96 MHz clk and are also used by the rgb_sinp benches.
package rgbw_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      RESET = 2'd3
   } state_t;

   localparam int DEF_BITS_PER_PIXEL = 32;
   localparam int DEF_T0H_CLKS       = 30;
   localparam int DEF_T0L_CLKS       = 80;
   localparam int DEF_T1H_CLKS       = 70;
   localparam int DEF_T1L_CLKS       = 40;
   localparam int DEF_RESET_CLKS     = 4800;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rgbw_sout_if.sv
// Pixel word valid/ready handshake into the serial LED encoder.
interface rgbw_sout_if #(
   parameter int BITS_PER_PIXEL = 32
) ();
   logic [BITS_PER_PIXEL-1:0] in_data;
   logic                      in_valid;
   logic                      in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rgbw_phase_timer.sv
// Loadable down-counter timing the HIGH, LOW and RESET phases.
// Load N-1 to get an N-cycle phase; done is high while the count sits at zero.
module rgbw_phase_timer #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);
   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);
endmodule

// File: rtl/rgbw_sout.sv
// Serial GRBW pixel encoder for WS2812/SK6812 strips: pulse-width coded bits, MSB first,
// with an optional low latch gap between pixels.
//
// state | meaning
// IDLE  | line low, waiting for a latch request or a held pixel
// HIGH  | high part of the current bit (T1H or T0H by current MSB)
// LOW   | low part of the current bit; pixel boundary handled at its end
// RESET | latch gap, line low for RESET_CLKS
module rgbw_sout
   import rgbw_pkg::*;
#(
   parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
   parameter int T0H_CLKS       = DEF_T0H_CLKS,
   parameter int T0L_CLKS       = DEF_T0L_CLKS,
   parameter int T1H_CLKS       = DEF_T1H_CLKS,
   parameter int T1L_CLKS       = DEF_T1L_CLKS,
   parameter int RESET_CLKS     = DEF_RESET_CLKS
) (
   input  logic        clk,
   input  logic        rst,
   rgbw_sout_if.slave  pix,
   input  logic        latch,
   output logic        out,
   output logic        busy
);
   localparam int MAX_CLKS = max2(max2(max2(T0H_CLKS, T0L_CLKS), max2(T1H_CLKS, T1L_CLKS)),
                                  RESET_CLKS);
   localparam int PW  = $clog2(MAX_CLKS + 1);
   localparam int BW  = $clog2(BITS_PER_PIXEL);
   localparam int MSB = BITS_PER_PIXEL - 1;

   if (T0H_CLKS < 1 || T0L_CLKS < 1 || T1H_CLKS < 1 || T1L_CLKS < 1 || RESET_CLKS < 1)
   begin : g_bad_timing
      $error("rgbw_sout: all timing parameters must be >= 1");
   end
   if (BITS_PER_PIXEL < 2) begin : g_bad_width
      $error("rgbw_sout: BITS_PER_PIXEL must be >= 2");
   end

   localparam logic [PW-1:0] T0H_LD   = PW'(T0H_CLKS - 1);
   localparam logic [PW-1:0] T0L_LD   = PW'(T0L_CLKS - 1);
   localparam logic [PW-1:0] T1H_LD   = PW'(T1H_CLKS - 1);
   localparam logic [PW-1:0] T1L_LD   = PW'(T1L_CLKS - 1);
   localparam logic [PW-1:0] RST_LD   = PW'(RESET_CLKS - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);

   state_t                    state_q, state_d;
   logic [BITS_PER_PIXEL-1:0] shift_q;
   logic [BITS_PER_PIXEL-1:0] hold_q;
   logic [BW-1:0]             bit_cnt_q;
   logic                      hold_valid_q;
   logic                      latch_pend_q;
   logic                      out_q;

   logic                      tmr_load;
   logic [PW-1:0]             tmr_val;
   logic                      tmr_done;
   logic                      boundary;
   logic                      take_hold;
   logic                      do_shift;
   logic                      enter_reset;
   logic                      accept;

   rgbw_phase_timer #(.WIDTH(PW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign accept = pix.in_valid && !hold_valid_q;

   always_comb begin
      state_d     = state_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      take_hold   = 1'b0;
      do_shift    = 1'b0;
      enter_reset = 1'b0;
      boundary    = 1'b0;

      unique case (state_q)
         IDLE: boundary = 1'b1;
         HIGH: begin
            if (tmr_done) begin
               state_d  = LOW;
               tmr_load = 1'b1;
               tmr_val  = shift_q[MSB] ? T1L_LD : T0L_LD;
            end
         end
         LOW: begin
            if (tmr_done) begin
               if (bit_cnt_q != '0) begin
                  state_d  = HIGH;
                  do_shift = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = shift_q[MSB-1] ? T1H_LD : T0H_LD;
               end else begin
                  state_d  = IDLE;
                  boundary = 1'b1;
               end
            end
         end
         RESET: begin
            if (tmr_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pixel boundary: a pending latch beats a held pixel, which beats going idle.
      if (boundary) begin
         if (latch_pend_q) begin
            state_d     = RESET;
            enter_reset = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = RST_LD;
         end else if (hold_valid_q) begin
            state_d   = HIGH;
            take_hold = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = hold_q[MSB] ? T1H_LD : T0H_LD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         latch_pend_q <= 1'b0;
         out_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= (state_d == HIGH);

         if (take_hold) begin
            shift_q   <= hold_q;
            bit_cnt_q <= LAST_BIT;
         end else if (do_shift) begin
            shift_q   <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
         end

         if (accept) hold_q <= pix.in_data;
         hold_valid_q <= accept || (hold_valid_q && !take_hold);
         latch_pend_q <= latch || (latch_pend_q && !enter_reset);
      end
   end

   assign pix.in_ready = !hold_valid_q;
   assign out          = out_q;
   assign busy         = (state_q != IDLE) || hold_valid_q || latch_pend_q;
endmodule
